l2_mem_responder: RTL and testbench
===================================

# l2_mem_responder

Synchronous memory-side responder for the L2-to-main-memory line-fill/write-back interface. It samples the address strobe issued by the L2 controller, waits a fixed access latency, then moves one cache line as a burst of 64-bit beats, pulsing `stb` once per beat. It sits below the L2 cache, replacing the untimed memory model with a cycle-accurate, clocked backing store that verification can reason about.

## Interface
- `LINE_BEATS`, 4: 64-bit beats per L2 line; power of two, 2..16.
- `LATENCY`, 8: cycles from accepted strobe to first beat; minimum 1.
- `MEM_WORDS`, 1024: depth of backing store in 64-bit words; power of two.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `addrstb`  in  1  request strobe from L2, sampled one cycle.
- `we`  in  1  1 = write-back line, 0 = line fill; sampled with `addrstb`.
- `addr`  in  32  byte address of the requested (critical) beat; bits [2:0] ignored.
- `wdata`  in  64  write beat; must be valid in every cycle `stb` is high on a write.
- `rdata`  out  64  read beat; valid only while `stb` high on a read.
- `stb`  out  1  beat strobe: one per beat, exactly LINE_BEATS per request.
- `busy`  out  1  request in progress; strobes ignored while high.

## Operation
- States: IDLE, WAIT, XFER.
- IDLE: `addrstb`=1 latches `we`, beat index `addr[3+log2(MEM_WORDS)-1:3]`, clears counters -> WAIT (or XFER directly when LATENCY=1).
- WAIT: latency counter counts to LATENCY-1 -> XFER.
- XFER: `stb`=1 each cycle; beat counter 0..LINE_BEATS-1; last beat -> IDLE.
- Beat order: critical-word-first with wrap inside the line. Beat k address = {line base, (start_offset + k) mod LINE_BEATS}; line base never changes during a burst.
- Read: `rdata` = mem[beat address] in the same cycle `stb` high (registered read issued one cycle ahead).
- Write: mem[beat address] <= `wdata` on the rising edge ending each `stb` cycle.
- Address index wraps modulo MEM_WORDS; upper address bits beyond the store are ignored, never an error.
- `addrstb` while `busy`=1 or in the final XFER cycle: ignored, no queueing.
- Memory contents are not cleared by reset and persist across reset.

## Timing
- Reset values: `stb`=0, `busy`=0, `rdata`=0, state IDLE, all counters 0.
- Strobe sampled in cycle T; `busy`=1 from T+1 through T+LATENCY+LINE_BEATS-1 inclusive.
- `stb` high cycles T+LATENCY .. T+LATENCY+LINE_BEATS-1, contiguous, no gaps.
- Next request accepted at earliest in cycle T+LATENCY+LINE_BEATS.
- `rdata` holds 0 when `stb`=0.
- Reset mid-burst: next cycle `stb`=0, `busy`=0, IDLE; write beats already committed stay written, remaining beats not written.
- `addrstb` coincident with `reset_n`=0: reset wins, request dropped.

## Configuration
- `MEM_STATS_EN` defined: adds outputs `rd_lines` and `wr_lines` (16 bits each, reset 0), incremented in the last XFER cycle of a read/write request respectively, saturating at 16'hFFFF.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset: hold `reset_n`=0 two cycles -> `stb`=0, `busy`=0, `rdata`=0.
- Write line at addr 0x0000_0100 with beats A0..A3 = 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444... strobed at T -> `stb` at T+8..T+11; subsequent read at 0x100 returns 1111,2222,3333,4444 at T'+8..T'+11.
- Critical-word-first: read at 0x0000_0110 of that line -> beats 3333,4444,1111,2222.
- Index wrap: write at 0x0000_2100 (MEM_WORDS=1024) then read 0x0000_0100 -> returns the 0x2100 data.
- Busy collision: `addrstb` at T+3 during read -> ignored, exactly 4 `stb` pulses; reset asserted at T+9 of a write -> only beat 0 updated, `stb`=0 at T+10.
- With `MEM_STATS_EN`: 2 reads + 1 write -> `rd_lines`=2, `wr_lines`=1; reset -> both 0.

Source files
------------

// File: rtl/l2_mem_responder_if.sv
// l2_mem_responder_if
//   Handshake/data bundle between the L2 controller (master) and the
//   memory-side responder (slave).
//   addrstb/we/addr : request strobe, direction (1 = write-back), byte address
//   wdata           : write beat, valid while stb is high on a write
//   rdata           : read beat, valid while stb is high on a read, else 0
//   stb             : one pulse per beat
//   busy            : request in progress, new strobes ignored
interface l2_mem_responder_if;
  logic        addrstb;
  logic        we;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        stb;
  logic        busy;

  modport master (output addrstb, we, addr, wdata, input rdata, stb, busy);
  modport slave  (input addrstb, we, addr, wdata, output rdata, stb, busy);
endinterface

// File: rtl/l2_mem_responder.sv
// l2_mem_responder
//   Clocked backing store below the L2. A sampled addrstb starts a request;
//   after LATENCY cycles a whole line moves as LINE_BEATS contiguous 64-bit
//   beats, critical word first with wrap inside the line.
//   Ports:
//     clk      : clock, rising edge
//     reset_n  : synchronous active-low reset (memory contents are kept)
//     bus      : l2_mem_responder_if.slave (addrstb, we, addr, wdata in;
//                rdata, stb, busy out)
//   Optional feature macro MEM_STATS_EN:
//     rd_lines / wr_lines : 16-bit saturating counts of completed read /
//                           write lines, cleared by reset.
module l2_mem_responder #(
  parameter int LINE_BEATS = 4,
  parameter int LATENCY    = 8,
  parameter int MEM_WORDS  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  l2_mem_responder_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]       rd_lines,
  output logic [15:0]       wr_lines
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int OW = $clog2(LINE_BEATS);
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  state_t           state, stateNxt;
  logic             weR;
  logic [AW-OW-1:0] lineBase;
  logic [OW-1:0]    startOff;
  logic [OW-1:0]    beatCnt;
  logic [LW-1:0]    latCnt;
  logic [63:0]      mem [MEM_WORDS];

  logic             accept, lastBeat, rdIssue, rdWe;
  logic [AW-OW-1:0] selBase;
  logic [OW-1:0]    selOff, rdBeat;
  logic [AW-1:0]    curAddr, rdAddr;
  logic             unusedAddr;

  // Byte-offset bits and bits above the store are deliberately dropped:
  // the word index wraps modulo MEM_WORDS.
  assign unusedAddr = ^{bus.addr[31:AW+3], bus.addr[2:0]};

  // Address of the beat being transferred this cycle.
  assign curAddr = {lineBase, OW'(startOff + beatCnt)};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    accept   = 1'b0;
    lastBeat = 1'b0;
    bus.stb  = (state == XFER);
    bus.busy = (state != IDLE);
    unique case (state)
      IDLE: if (bus.addrstb) begin
        accept   = 1'b1;
        stateNxt = (LATENCY == 1) ? XFER : WAIT;
      end
      WAIT: if (latCnt == LW'(LATENCY - 1)) stateNxt = XFER;
      XFER: if (beatCnt == OW'(LINE_BEATS - 1)) begin
        lastBeat = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // The read port is registered, so the word for next cycle's beat is
  // fetched now. When a request is accepted straight into XFER
  // (LATENCY == 1) the request fields are still on the bus, not latched.
  always_comb begin
    selBase = accept ? bus.addr[AW+2:OW+3] : lineBase;
    selOff  = accept ? bus.addr[OW+2:3]    : startOff;
    rdWe    = accept ? bus.we              : weR;
    rdBeat  = (state == XFER) ? OW'(beatCnt + 1'b1) : '0;
    rdAddr  = {selBase, OW'(selOff + rdBeat)};
    rdIssue = (stateNxt == XFER) && !rdWe;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      weR       <= 1'b0;
      lineBase  <= '0;
      startOff  <= '0;
      beatCnt   <= '0;
      latCnt    <= '0;
      bus.rdata <= '0;
    end else begin
      if (accept) begin
        weR      <= bus.we;
        lineBase <= bus.addr[AW+2:OW+3];
        startOff <= bus.addr[OW+2:3];
        beatCnt  <= '0;
        // The accept cycle itself is the first latency cycle.
        latCnt   <= LW'(1);
      end
      if (state == WAIT) latCnt  <= latCnt + 1'b1;
      if (state == XFER) beatCnt <= beatCnt + 1'b1;
      bus.rdata <= rdIssue ? mem[rdAddr] : '0;
    end
  end

  // No reset on the array; a reset edge only blocks the write in flight.
  always_ff @(posedge clk) begin
    if (reset_n && state == XFER && weR) mem[curAddr] <= bus.wdata;
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_lines <= '0;
      wr_lines <= '0;
    end else if (lastBeat) begin
      if (weR && wr_lines != 16'hFFFF)  wr_lines <= wr_lines + 1'b1;
      if (!weR && rd_lines != 16'hFFFF) rd_lines <= rd_lines + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb_l2_mem_responder
//   Directed bench for l2_mem_responder at default parameters
//   (LINE_BEATS=4, LATENCY=8, MEM_WORDS=1024). Inputs change 1 ns after
//   the rising edge; outputs are sampled on the falling edge.
module tb_l2_mem_responder;
  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  l2_mem_responder_if bus();
`ifdef MEM_STATS_EN
  logic [15:0] rdLines, wrLines;
`endif

  l2_mem_responder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef MEM_STATS_EN
    ,
    .rd_lines(rdLines),
    .wr_lines(wrLines)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request strobed in cycle T, checked cycle by cycle through T+12.
  // collideAt: cycle offset at which a stray addrstb is driven (0 = none).
  // rstAt: cycle offset at which reset_n is pulled low for one cycle (0 = none).
  task automatic burst(input logic w, input logic [31:0] a,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2, input logic [63:0] d3,
                       input int collideAt, input int rstAt);
    logic [63:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    bus.addrstb = 1'b1; bus.we = w; bus.addr = a;
    @(posedge clk); #1;
    for (int c = 1; c <= 11; c++) begin
      bus.addrstb = (c == collideAt);
      bus.we      = ~w;
      bus.addr    = 32'h0000_0300;
      bus.wdata   = (w && c >= 8) ? d[(c-8) & 3] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (c == rstAt) reset_n = 1'b0;
      @(negedge clk);
      chk($sformatf("busy@T+%0d", c), bus.busy, 1'b1);
      chk($sformatf("stb@T+%0d", c), bus.stb, c >= 8);
      if (!w) chk($sformatf("rdata@T+%0d", c), bus.rdata, (c >= 8) ? d[(c-8) & 3] : 64'h0);
      @(posedge clk); #1;
      if (c == rstAt) begin
        reset_n = 1'b1;
        break;
      end
    end
    bus.addrstb = 1'b0;
    @(negedge clk);
    chk("busy_after", bus.busy, 1'b0);
    chk("stb_after", bus.stb, 1'b0);
    chk("rdata_after", bus.rdata, 64'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.addrstb = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stb", bus.stb, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rdata", bus.rdata, 64'h0);
`ifdef MEM_STATS_EN
    chk("rst_rd_lines", rdLines, 16'h0);
    chk("rst_wr_lines", wrLines, 16'h0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill offsets 0..3 of the line at word 0x20.
    burst(1'b1, 32'h0000_0100, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 0);
    // Read back in order; stray strobe at T+3 must be dropped.
    burst(1'b0, 32'h0000_0100, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 3, 0);
    // Critical word first from offset 2; stray strobe in the last beat.
    burst(1'b0, 32'h0000_0110, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
          64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 11, 0);
    // 0x2100 aliases 0x100 in a 1024-word store.
    burst(1'b1, 32'h0000_2100, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
          64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD, 0, 0);
    burst(1'b0, 32'h0000_0100, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
          64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD, 0, 0);
`ifdef MEM_STATS_EN
    chk("stats_rd_lines", rdLines, 16'd3);
    chk("stats_wr_lines", wrLines, 16'd2);
`endif
    // Write interrupted by reset in T+9: only beat 0 lands.
    burst(1'b1, 32'h0000_0100, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
          64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 0, 9);
`ifdef MEM_STATS_EN
    chk("stats_rd_after_rst", rdLines, 16'd0);
    chk("stats_wr_after_rst", wrLines, 16'd0);
`endif
    burst(1'b0, 32'h0000_0100, 64'h5555_5555_5555_5555, 64'hBBBB_BBBB_BBBB_BBBB,
          64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD, 0, 0);
`ifdef MEM_STATS_EN
    chk("stats_rd_one", rdLines, 16'd1);
    chk("stats_wr_zero", wrLines, 16'd0);
`endif

    // Strobe coincident with reset is dropped.
    reset_n = 1'b0; bus.addrstb = 1'b1; bus.we = 1'b0; bus.addr = 32'h0000_0100;
    @(posedge clk); #1;
    reset_n = 1'b1; bus.addrstb = 1'b0;
    @(negedge clk);
    chk("rst_strobe_busy", bus.busy, 1'b0);
    chk("rst_strobe_stb", bus.stb, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("rst_strobe_no_burst", bus.stb, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
